arbiter_rr: RTL

//  N-requester arbiter; parametrised successor of the 2-port req/gnt arbiter.

---
 rtl/arbiter_rr_pkg.sv | 15 +
 rtl/arbiter_rr_pick.sv | 43 ++++
 rtl/arbiter_rr.sv | 101 ++++++++++
 3 files changed

// File: rtl/arbiter_rr_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package arbiter_rr_pkg;

   // Arbiter FSM: no owner, or an owner holding the grant
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Index width for n items; never below one bit so N==1 still has a gnt_id port
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational circular winner search: first eligible request at or after
// 'start', wrapping from N-1 back to 0, optionally excluding one index.
module arbiter_rr_pick
   import arbiter_rr_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = id_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] start,
   input  logic            mask_en,
   input  logic [ID_W-1:0] mask_id,
   output logic            found,
   output logic [ID_W-1:0] win_id,
   output logic [N-1:0]    win_onehot
);

   logic [N-1:0] eligible;

   // Rotate/priority-encode/unrotate folded into one loop: scanning offsets from
   // far to near lets the nearest eligible offset overwrite the result last.
   always_comb begin
      eligible = req;
      if (mask_en) begin
         for (int i = 0; i < N; i++) begin
            if (ID_W'(i) == mask_id) eligible[i] = 1'b0;
         end
      end
      found  = 1'b0;
      win_id = '0;
      for (int k = N - 1; k >= 0; k--) begin
         int idx;
         idx = int'(start) + k;
         if (idx >= N) idx = idx - N;
         if (eligible[idx]) begin
            found  = 1'b1;
            win_id = ID_W'(idx);
         end
      end
      win_onehot = found ? (N'(1) << win_id) : '0;
   end

endmodule

// File: rtl/arbiter_rr.sv
// N-requester arbiter with registered one-hot grant, run-time selectable
// round-robin / fixed priority, and an optional hold limit that preempts a
// long-running owner while other requesters are waiting.
module arbiter_rr
   import arbiter_rr_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int ID_W     = id_width(N)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [N-1:0]    req,
   input  logic            prio_fixed,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id
);

   localparam int HOLD_W = id_width(MAX_HOLD + 1);
   // With no limit the counter just parks at all-ones; it is never compared then
   localparam logic [HOLD_W-1:0] HOLD_SAT =
      HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : ((1 << HOLD_W) - 1));
   localparam bit HOLD_LIMITED = (MAX_HOLD > 0);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N-1:0]      gnt_q, gnt_d;

   logic              found;
   logic [ID_W-1:0]   win_id;
   logic [N-1:0]      win_onehot;
   logic [ID_W-1:0]   start;
   logic              others_pending;
   logic              preempt;
   logic              keep;

   // Fixed priority always searches from index 0; round-robin from the pointer.
   // The owner is masked in GRANT: it either dropped req or is being preempted.
   assign start          = prio_fixed ? '0 : ptr_q;
   assign others_pending = |(req & ~gnt_q);
   assign preempt        = HOLD_LIMITED && (hold_q == HOLD_SAT) && others_pending;
   assign keep           = (state_q == ST_GRANT) && (|(req & gnt_q)) && !preempt;

   arbiter_rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
      .req        (req),
      .start      (start),
      .mask_en    (state_q == ST_GRANT),
      .mask_id    (owner_q),
      .found      (found),
      .win_id     (win_id),
      .win_onehot (win_onehot)
   );

   // Next-state: keep the owner, hand over without a bubble, or go idle
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      if (keep) begin
         if (hold_q != HOLD_SAT) hold_d = hold_q + 1'b1;
      end else if (found) begin
         state_d = ST_GRANT;
         owner_d = win_id;
         gnt_d   = win_onehot;
         hold_d  = '0;
         if (!prio_fixed) ptr_d = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;
      end else begin
         state_d = ST_IDLE;
         owner_d = '0;
         gnt_d   = '0;
         hold_d  = '0;
      end
   end

   // State and output registers; reset clears the grant asynchronously
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = owner_q;

endmodule
